hex_pio_master: RTL and testbench

HEX_PIO_MASTER -- requirements
Module: hex_pio_master

---
 rtl/hex_pio_master.sv | 179 +++++++++++++++++
 tb/tb_hex_pio_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_pio_master.sv
// hex_pio_master: single-outstanding command engine for an Avalon-MM slave with
// optional write-verify, per-access stall timeout and fixed read latency.
module hex_pio_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] VERIFY_MASK  = 32'h0000_00FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_verify,
  input  logic [1:0]  cmd_address,
  input  logic [31:0] cmd_data,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic        avm_read_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned WAIT_W = 16;
  localparam int unsigned LAT_W  = 2;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0]  LAT_INIT   = LAT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RSP} state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic [LAT_W-1:0]    lat_cnt, lat_nxt;
  logic                is_write, is_write_nxt;
  logic                is_verify, is_verify_nxt;
  logic [ADDR_W-1:0]   address_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [DATA_W-1:0]   rsp_data_nxt;
  logic                rsp_error_nxt, rsp_valid_nxt;
  logic                cs_nxt, write_n_nxt, read_n_nxt, ready_nxt, busy_nxt;
  logic                verify_err_c;

  // Masked compare of returned data against the latched write data.
  assign verify_err_c = |((avm_readdata ^ avm_writedata) & VERIFY_MASK);

  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    lat_nxt       = lat_cnt;
    is_write_nxt  = is_write;
    is_verify_nxt = is_verify;
    address_nxt   = avm_address;
    wdata_nxt     = avm_writedata;
    rsp_data_nxt  = rsp_data;
    rsp_error_nxt = rsp_error;
    rsp_valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          is_write_nxt  = cmd_write;
          is_verify_nxt = cmd_verify;
          address_nxt   = cmd_address;
          wdata_nxt     = cmd_data;
          wait_nxt      = '0;
          state_nxt     = cmd_write ? WR : RD;
        end
      end
      WR: begin
        if (!avm_waitrequest) begin
          wait_nxt = '0;
          if (is_verify) begin
            state_nxt = RD;
          end else begin
            state_nxt     = RSP;
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = avm_writedata;
            rsp_error_nxt = 1'b0;
          end
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_nxt     = RSP;
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = '0;
          rsp_error_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      RD: begin
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            state_nxt     = RSP;
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = avm_readdata;
            rsp_error_nxt = is_write & verify_err_c;
          end else begin
            state_nxt = RWAIT;
            lat_nxt   = LAT_INIT;
          end
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_nxt     = RSP;
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = '0;
          rsp_error_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      RWAIT: begin
        // Data is due READ_LATENCY edges after the accepting edge.
        if (lat_cnt == '0) begin
          state_nxt     = RSP;
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = avm_readdata;
          rsp_error_nxt = is_write & verify_err_c;
        end else begin
          lat_nxt = lat_cnt - LAT_W'(1);
        end
      end
      RSP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Bus strobes and handshakes follow the state being entered.
    cs_nxt      = (state_nxt == WR) || (state_nxt == RD);
    write_n_nxt = (state_nxt != WR);
    read_n_nxt  = (state_nxt != RD);
    ready_nxt   = (state_nxt == IDLE);
    busy_nxt    = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      lat_cnt        <= '0;
      is_write       <= 1'b0;
      is_verify      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read_n     <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_error      <= 1'b0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      wait_cnt       <= wait_nxt;
      lat_cnt        <= lat_nxt;
      is_write       <= is_write_nxt;
      is_verify      <= is_verify_nxt;
      avm_address    <= address_nxt;
      avm_writedata  <= wdata_nxt;
      avm_chipselect <= cs_nxt;
      avm_write_n    <= write_n_nxt;
      avm_read_n     <= read_n_nxt;
      rsp_valid      <= rsp_valid_nxt;
      rsp_data       <= rsp_data_nxt;
      rsp_error      <= rsp_error_nxt;
      cmd_ready      <= ready_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_hex_pio_master.sv
// tb_hex_pio_master: directed and random commands against a stalling slave,
// checked against a transaction-level reference of strobes, latency and response.
module tb_hex_pio_master;

  localparam int unsigned RL   = 2;
  localparam int unsigned TO   = 4;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_verify;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_data;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic        avm_read_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        busy;

  int checks;
  int failures;

  hex_pio_master #(
    .READ_LATENCY(RL),
    .TIMEOUT     (TO),
    .VERIFY_MASK (MASK)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_verify     (cmd_verify),
    .cmd_address    (cmd_address),
    .cmd_data       (cmd_data),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_read_n     (avm_read_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_error      (rsp_error),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cs"},      32'(avm_chipselect), 32'd0);
    check({tag, "_write_n"}, 32'(avm_write_n),    32'd1);
    check({tag, "_read_n"},  32'(avm_read_n),     32'd1);
    check({tag, "_addr"},    32'(avm_address),    32'd0);
    check({tag, "_wdata"},   avm_writedata,       32'd0);
    check({tag, "_rvalid"},  32'(rsp_valid),      32'd0);
    check({tag, "_rerr"},    32'(rsp_error),      32'd0);
    check({tag, "_rdata"},   rsp_data,            32'd0);
    check({tag, "_busy"},    32'(busy),           32'd0);
  endtask

  // Called at a negedge while IDLE; returns at the negedge where IDLE is seen again.
  task automatic run_cmd(input string tag, input logic wr, input logic vf,
                         input logic [1:0] addr, input logic [31:0] data,
                         input int s_wr, input int s_rd, input logic [31:0] rdata);
    int exp_wr, exp_rd, exp_cyc, nwr, nrd, viol, npulse, acc, rsp_cyc, rdy_cyc, cyc;
    logic to_wr, to_rd, do_rd, timed_out, exp_err, got_err;
    logic [31:0] exp_data, got_data;

    exp_wr    = wr ? ((s_wr < int'(TO)) ? s_wr + 1 : int'(TO)) : 0;
    to_wr     = wr && (s_wr >= int'(TO));
    do_rd     = !wr || (vf && !to_wr);
    exp_rd    = do_rd ? ((s_rd < int'(TO)) ? s_rd + 1 : int'(TO)) : 0;
    to_rd     = do_rd && (s_rd >= int'(TO));
    timed_out = to_wr || to_rd;
    exp_cyc   = exp_wr + exp_rd + ((do_rd && !to_rd) ? int'(RL) : 0);
    exp_data  = timed_out ? 32'd0 : (wr && !vf) ? data : rdata;
    exp_err   = timed_out || (wr && vf && (((rdata ^ data) & MASK) != 32'd0));

    nwr = 0; nrd = 0; viol = 0; npulse = 0; acc = -1; rsp_cyc = -1; rdy_cyc = -1;
    got_data = 32'd0; got_err = 1'b0;

    cmd_valid = 1'b1; cmd_write = wr; cmd_verify = vf; cmd_address = addr; cmd_data = data;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (rdy_cyc < 0 && cyc < 200) begin
      // Junk on the command port must be ignored while busy.
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_verify = 1'($urandom);
      cmd_address = 2'($urandom); cmd_data = $urandom;
      if (!avm_write_n && !avm_read_n) viol++;
      if (avm_chipselect == (avm_write_n && avm_read_n)) viol++;
      if (busy === cmd_ready) viol++;
      if (!avm_write_n) begin
        nwr++;
        if (avm_address !== addr || avm_writedata !== data) viol++;
        avm_waitrequest = (nwr <= s_wr);
      end else if (!avm_read_n) begin
        nrd++;
        if (avm_address !== addr) viol++;
        avm_waitrequest = (nrd <= s_rd);
        if (!avm_waitrequest) acc = cyc;
      end else begin
        avm_waitrequest = 1'($urandom);
      end
      avm_readdata = (acc >= 0 && cyc == acc + int'(RL)) ? rdata : ~rdata;
      if (rsp_valid) begin
        npulse++; rsp_cyc = cyc; got_data = rsp_data; got_err = rsp_error;
      end
      if (cmd_ready) begin
        rdy_cyc = cyc;
        cmd_valid = 1'b0;
      end else begin
        cyc++;
        @(negedge clk);
      end
    end

    check({tag, "_rsp_data"},  got_data,       exp_data);
    check({tag, "_rsp_error"}, 32'(got_err),   32'(exp_err));
    check({tag, "_rsp_cycle"}, 32'(rsp_cyc),   32'(exp_cyc));
    check({tag, "_ready_cyc"}, 32'(rdy_cyc),   32'(exp_cyc + 1));
    check({tag, "_pulses"},    32'(npulse),    32'd1);
    check({tag, "_wr_cycles"}, 32'(nwr),       32'(exp_wr));
    check({tag, "_rd_cycles"}, 32'(nrd),       32'(exp_rd));
    check({tag, "_protocol"},  32'(viol),      32'd0);
  endtask

  initial begin
    logic        wr, vf;
    logic [31:0] d, rd;
    int          seen_valid;

    checks = 0; failures = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_verify = 1'b0;
    cmd_address = 2'd0; cmd_data = 32'd0; avm_readdata = 32'd0; avm_waitrequest = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    check("por_ready", 32'(cmd_ready), 32'd1);

    // Directed scenarios.
    run_cmd("wr_plain",      1'b1, 1'b0, 2'd0, 32'h0000_005A, 0, 0, 32'h0);
    run_cmd("vfy_masked_ok", 1'b1, 1'b1, 2'd1, 32'h0000_003C, 0, 0, 32'hFFFF_FF3C);
    run_cmd("vfy_mismatch",  1'b1, 1'b1, 2'd2, 32'h0000_003C, 0, 0, 32'h0000_0000);
    run_cmd("rd_stall3",     1'b0, 1'b0, 2'd3, 32'h0,         0, 3, 32'h1234_5678);
    run_cmd("rd_timeout",    1'b0, 1'b0, 2'd1, 32'h0,         0, 4, 32'hCAFE_F00D);
    run_cmd("wr_timeout",    1'b1, 1'b0, 2'd2, 32'hA5A5_0001, 4, 0, 32'h0);
    run_cmd("vfy_wr_to",     1'b1, 1'b1, 2'd3, 32'h0000_0077, 6, 0, 32'h0000_0077);
    run_cmd("vfy_rd_to",     1'b1, 1'b1, 2'd0, 32'h0000_0011, 1, 4, 32'h0000_0011);
    run_cmd("wr_stall3",     1'b1, 1'b0, 2'd1, 32'h8000_0000, 3, 0, 32'h0);

    // Randomized commands and stall patterns.
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom); vf = 1'($urandom); d = $urandom;
      rd = $urandom;
      if (vf && 1'($urandom)) rd = {rd[31:8], d[7:0]};
      run_cmd($sformatf("rand%0d", i), wr, vf, 2'($urandom), d,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), rd);
    end

    // Reset while waiting for read data.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_verify = 1'b0;
    cmd_address = 2'd2; cmd_data = 32'hDEAD_BEEF; avm_waitrequest = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rwait_pre_rd", 32'(avm_read_n), 32'd0);
    @(negedge clk);
    check("rwait_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("rst_rwait");
    reset = 1'b0;
    check("rst_rwait_ready", 32'(cmd_ready), 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid++;
    end
    check("rst_rwait_no_rsp", 32'(seen_valid), 32'd0);
    check("rst_rwait_idle", 32'(cmd_ready), 32'd1);

    run_cmd("post_reset_wr", 1'b1, 1'b0, 2'd3, 32'h0BAD_CAFE, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
